jt10_adpcma_regs: RTL
=====================

Name: jt10_adpcma_regs

Overview:
- ADPCM-A control front end for the six channels.
- Captures CPU writes to the ADPCM-A register bank: key on/off, start address LSB/MSB and end address LSB/MSB.
- Replays those writes into the six-slot time-multiplexed address-counter pipeline, presenting each update only in its channel's slot.
- Sits directly upstream of the ADPCM-A address counter. It also generates that counter's slot alignment and its div3 sample-rate strobe.

Parameters:
- none (channel count fixed at 6, address width fixed at 12)

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  CPU clock
- cen  in  1  clock enable for slot/round sequencing; tie 1'b1 if unused
- wr  in  1  register write strobe, one clk cycle, sampled regardless of cen
- wr_addr  in  8  register address
- wr_din  in  8  register data
- slot  out  3  channel currently at counter stage 1, range 0..5
- div3  out  1  sample-period window: high for one full round of 6 slots out of every 3 rounds
- addr_in  out  12  start or end address for the current slot
- up_start  out  1  addr_in is a new start address for the current slot
- up_end  out  1  addr_in is a new end address for the current slot
- aon  out  1  key-on for the current slot
- aoff  out  1  key-off for the current slot

Behaviour:
- Reset (async): slot=0, round=0, all shadow regs 0, all pending flags 0. Outputs: div3=1, all other outputs 0.
- Slot counter: on cen, slot advances 0,1,..,5,0. On wrap, round advances 0,1,2,0. div3 = (round==0), registered. cen low freezes slot, round and all pending-flag clears.
- Register map, decoded on wr:
  - 0x00 key: bit7=0 -> for every set bit i in din[5:0], on_pend[i]=1 and off_pend[i]=0. bit7=1 -> off_pend[i]=1 and on_pend[i]=0.
  - 0x10+i start LSB, 0x18+i start MSB (din[3:0] only), for i=0..5. Updates start[i] and sets st_pend[i].
  - 0x20+i end LSB, 0x28+i end MSB (din[3:0] only). Updates end[i] and sets en_pend[i].
  - Other addresses, including i=6,7, are ignored.
- Outputs are combinational from registered state indexed by slot:
  - aon=on_pend[slot]; aoff=off_pend[slot].
  - up_start=st_pend[slot].
  - up_end=en_pend[slot] && !st_pend[slot].
  - addr_in=start[slot] if st_pend[slot], else end[slot] if en_pend[slot], else 0.
- Consumption: on cen, each flag visible at the current slot is cleared. Only one of st/en is consumed per slot visit; a pending end is emitted on the following round.
- Write in the same clk as the consuming cen for the same channel: set wins, so the flag stays pending and is emitted again 6 cen later.
- Write latency: a flag set at edge N is visible from clk N+1 when slot matches.
- Max emission delay after a write is 6 cen cycles (12 if start and end are both pending).
- No effect on other channels. Reset mid-round returns to slot 0 and drops all pending flags.

Decomposition:
- Shared package jt10_adpcma_pkg: register address constants (KEY=0x00, STL=0x10, STH=0x18, ENL=0x20, ENH=0x28), NCH=6, slot type 3-bit.
- One natural sub-module, jt10_adpcma_slot: slot/round counter and div3 generation. The counter block reuses it for stand-alone tests.

Test Plan:
- Reset, then 20 cen -> slot sequence 0..5 repeating; div3 high for cen 0-5, low for 6-17, high again at cen 18.
- Write 0x12=0x34, then 0x1A=0xF5 -> within 6 cen, in slot 2: up_start=1, addr_in=0x534, for exactly one cen; never asserted in other slots.
- Write 0x11=0xAA and 0x21=0xBB (MSBs 0) -> slot 1 round k: up_start, addr_in=0x0AA. Slot 1 round k+1: up_end, addr_in=0x0BB.
- Write 0x00=0x05 -> aon in slots 0 and 2 once each. Then write 0x00=0x81 -> aoff in slot 0 only. A key-on followed by a key-off to ch0 before slot 0 -> only aoff emitted.
- Write 0x00=0x08 in the exact clk where slot=3 consumes a prior on_pend[3] -> aon seen at slot 3 now and again 6 cen later.
- Write 0x16=0xFF and 0x2E=0x01 -> no up_start/up_end in any slot; assert rst_n low mid-round with pending flags -> all outputs cleared immediately, no stale emission after release.

Source files
------------

// File: rtl/jt10_adpcma_pkg.sv
// Shared definitions for the ADPCM-A control front end: register map,
// channel count and the small types used across the block.
package jt10_adpcma_pkg;

  localparam int NCH = 6;
  localparam int AW  = 12;

  typedef logic [2:0]    slot_t;
  typedef logic [AW-1:0] addr_t;

  localparam logic [7:0] KEY = 8'h00;
  localparam logic [7:0] STL = 8'h10;
  localparam logic [7:0] STH = 8'h18;
  localparam logic [7:0] ENL = 8'h20;
  localparam logic [7:0] ENH = 8'h28;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_KEY,
    REG_STL,
    REG_STH,
    REG_ENL,
    REG_ENH
  } reg_sel_e;

  // Per-channel registers occupy the low three address bits; only 0..5 exist.
  function automatic reg_sel_e decode(input logic [7:0] a);
    reg_sel_e r;
    r = REG_NONE;
    if (a == KEY) begin
      r = REG_KEY;
    end else if (a[2:0] < 3'(NCH)) begin
      case ({a[7:3], 3'b000})
        STL:     r = REG_STL;
        STH:     r = REG_STH;
        ENL:     r = REG_ENL;
        ENH:     r = REG_ENH;
        default: r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/jt10_adpcma_regs_if.sv
// CPU write port of the ADPCM-A register bank.
interface jt10_adpcma_regs_if;
  logic       wr;
  logic [7:0] wr_addr;
  logic [7:0] wr_din;

  modport master (output wr, wr_addr, wr_din);
  modport slave  (input  wr, wr_addr, wr_din);
endinterface

// File: rtl/jt10_adpcma_slot.sv
// Six-slot sequencer with a three-round counter; div3 marks the first round
// of every three and is held in a flop so downstream sees a clean strobe.
module jt10_adpcma_slot
  import jt10_adpcma_pkg::*;
(
  input  logic  rst_n,
  input  logic  clk,
  input  logic  cen,
  output slot_t slot,
  output logic  div3
);

  slot_t      r_slot;
  logic [1:0] r_round;
  logic       r_div3;
  logic [1:0] w_round_nxt;

  assign w_round_nxt = (r_round == 2'd2) ? 2'd0 : r_round + 2'd1;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_round <= '0;
      r_div3  <= 1'b1;
    end else if (cen) begin
      if (r_slot == slot_t'(NCH - 1)) begin
        r_slot  <= '0;
        r_round <= w_round_nxt;
        r_div3  <= (w_round_nxt == 2'd0);
      end else begin
        r_slot <= r_slot + slot_t'(1);
      end
    end
  end

  assign slot = r_slot;
  assign div3 = r_div3;

endmodule

// File: rtl/jt10_adpcma_regs.sv
// ADPCM-A register bank: captures CPU writes and replays each channel's
// pending update into the address counter during that channel's slot.
module jt10_adpcma_regs
  import jt10_adpcma_pkg::*;
(
  input  logic  rst_n,
  input  logic  clk,
  input  logic  cen,
  jt10_adpcma_regs_if.slave bus,
  output slot_t slot,
  output logic  div3,
  output addr_t addr_in,
  output logic  up_start,
  output logic  up_end,
  output logic  aon,
  output logic  aoff
);

  logic [NCH-1:0] r_on, r_off, r_st, r_en;
  addr_t          r_start [NCH];
  addr_t          r_end   [NCH];

  reg_sel_e       w_sel;
  slot_t          w_ch;
  logic [NCH-1:0] w_ch_oh, w_slot_oh;
  logic [NCH-1:0] w_key_on, w_key_off, w_st_set, w_en_set;
  logic [NCH-1:0] w_clr_st, w_clr_en;

  jt10_adpcma_slot u_slot (
    .rst_n (rst_n),
    .clk   (clk),
    .cen   (cen),
    .slot  (slot),
    .div3  (div3)
  );

  assign w_sel     = decode(bus.wr_addr);
  assign w_ch      = bus.wr_addr[2:0];
  assign w_ch_oh   = NCH'(1) << w_ch;
  assign w_slot_oh = cen ? (NCH'(1) << slot) : '0;

  // A slot visit consumes the start update first; the end waits a round.
  assign w_clr_st  = r_st[slot] ? w_slot_oh : '0;
  assign w_clr_en  = r_st[slot] ? '0 : w_slot_oh;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_key_on  = '0;
    w_key_off = '0;
    w_st_set  = '0;
    w_en_set  = '0;
    if (bus.wr) begin
      case (w_sel)
        REG_KEY: begin
          if (bus.wr_din[7]) w_key_off = bus.wr_din[NCH-1:0];
          else               w_key_on  = bus.wr_din[NCH-1:0];
        end
        REG_STL, REG_STH: w_st_set = w_ch_oh;
        REG_ENL, REG_ENH: w_en_set = w_ch_oh;
        default: ;
      endcase
    end
  end

  // Clears are applied before sets, so a write landing on the consuming
  // cycle keeps its flag pending for the next visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on  <= '0;
      r_off <= '0;
      r_st  <= '0;
      r_en  <= '0;
    end else begin
      r_on  <= (r_on  & ~w_slot_oh & ~w_key_off) | w_key_on;
      r_off <= (r_off & ~w_slot_oh & ~w_key_on)  | w_key_off;
      r_st  <= (r_st  & ~w_clr_st) | w_st_set;
      r_en  <= (r_en  & ~w_clr_en) | w_en_set;
    end
  end

  // NOTE: the address shadows are small and must read as zero after reset,
  // so they sit on the async reset rather than in an uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
      end
    end else if (bus.wr) begin
      for (int i = 0; i < NCH; i++) begin
        if (w_ch == slot_t'(i)) begin
          case (w_sel)
            REG_STL: r_start[i][7:0]  <= bus.wr_din;
            REG_STH: r_start[i][11:8] <= bus.wr_din[3:0];
            REG_ENL: r_end[i][7:0]    <= bus.wr_din;
            REG_ENH: r_end[i][11:8]   <= bus.wr_din[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign aon      = r_on[slot];
  assign aoff     = r_off[slot];
  assign up_start = r_st[slot];
  assign up_end   = r_en[slot] && !r_st[slot];

  always_comb begin
    addr_in = '0;
    if (r_st[slot])      addr_in = r_start[slot];
    else if (r_en[slot]) addr_in = r_end[slot];
  end

endmodule
